// File: rtl/regfile_mp.sv
// Two-write, two-read register file with operand forwarding, a pending
// (scoreboard) bit per register, and a sequential clear engine.
module regfile_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] wa0,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  output logic          busy1,
  output logic          busy2,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  localparam int NREG = 2**AW;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [DW-1:0] rf [NREG];
  logic [NREG-1:0] pend;
  logic          idle, commit0, commit1, rsv_ok;

  function automatic logic is_r0(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  function automatic logic fwd_hit(input logic act, input logic we,
                                   input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    return (BYPASS != 0) && act && we && (wa == ra) && !is_r0(ra);
  endfunction

  assign idle    = (state == IDLE);
  assign commit1 = idle && we1 && !is_r0(wa1);
  // Port 1 wins a same-address collision, so port 0 steps aside.
  assign commit0 = idle && we0 && !is_r0(wa0) && !(we1 && (wa0 == wa1));
  assign rsv_ok  = idle && rsv_en && !is_r0(rsv_addr);

  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (idx == {AW{1'b1}}) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) idx <= idx + 1'b1;
      else                idx <= '0;
    end
  end

  // Reservation is applied last so it overrides a same-address write clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      pend <= '0;
    end else if (state == CLEAR) begin
      rf[idx]   <= '0;
      pend[idx] <= 1'b0;
    end else begin
      if (commit0) begin
        rf[wa0]   <= wd0;
        pend[wa0] <= 1'b0;
      end
      if (commit1) begin
        rf[wa1]   <= wd1;
        pend[wa1] <= 1'b0;
      end
      if (rsv_ok) pend[rsv_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd1   = is_r0(ra1) ? '0 : rf[ra1];
    busy1 = pend[ra1];
    if (fwd_hit(idle, we0, wa0, ra1)) begin
      rd1   = wd0;
      busy1 = 1'b0;
    end
    if (fwd_hit(idle, we1, wa1, ra1)) begin
      rd1   = wd1;
      busy1 = 1'b0;
    end
  end

  always_comb begin
    rd2   = is_r0(ra2) ? '0 : rf[ra2];
    busy2 = pend[ra2];
    if (fwd_hit(idle, we0, wa0, ra2)) begin
      rd2   = wd0;
      busy2 = 1'b0;
    end
    if (fwd_hit(idle, we1, wa1, ra2)) begin
      rd2   = wd1;
      busy2 = 1'b0;
    end
  end

  assign dbg_data = is_r0(dbg_sel) ? '0 : rf[dbg_sel];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp against an array-based
// reference model of the register file, pending bits and clear sequence.
`timescale 1ns/1ps
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          we0, we1, rsv_en, clr_req;
  logic [AW-1:0] wa0, wa1, ra1, ra2, rsv_addr, dbg_sel;
  logic [DW-1:0] wd0, wd1;
  logic [DW-1:0] rd1, rd2, dbg_data;
  logic          busy1, busy2, clr_busy, clr_done;

  regfile_mp #(.DW(DW), .AW(AW), .ZERO_R0(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1), .busy2(busy2),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = normal, 1 = clearing, 2 = clear just finished.
  logic [DW-1:0] m_rf [NREG];
  bit            m_pend [NREG];
  int            mode;
  int            ccnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_rf[i]   = '0;
      m_pend[i] = 1'b0;
    end
    mode = 0;
    ccnt = 0;
  endtask

  function automatic logic fwd(input logic [AW-1:0] ra);
    return (mode == 0) && (ra != 0) && ((we1 && wa1 == ra) || (we0 && wa0 == ra));
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (mode == 0 && ra != 0 && we1 && wa1 == ra) return wd1;
    if (mode == 0 && ra != 0 && we0 && wa0 == ra) return wd0;
    return (ra == 0) ? '0 : m_rf[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    return fwd(ra) ? 1'b0 : m_pend[ra];
  endfunction

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (mode == 0) begin
      if (we1 && wa1 != 0) begin
        m_rf[wa1] = wd1; m_pend[wa1] = 1'b0;
      end
      if (we0 && wa0 != 0 && !(we1 && wa1 == wa0)) begin
        m_rf[wa0] = wd0; m_pend[wa0] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      if (clr_req) begin
        mode = 1; ccnt = 0;
      end
    end else if (mode == 1) begin
      m_rf[ccnt] = '0;
      m_pend[ccnt] = 1'b0;
      ccnt++;
      if (ccnt == NREG) mode = 2;
    end else begin
      mode = 0;
    end
  endtask

  // One clock: check outputs mid-cycle, take the edge, advance the model.
  task automatic cyc();
    #1;
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("busy1", busy1, exp_busy(ra1));
    chk("busy2", busy2, exp_busy(ra2));
    chk("clr_busy", clr_busy, mode == 1);
    chk("clr_done", clr_done, mode == 2);
    chk("dbg_data", dbg_data, (dbg_sel == 0) ? '0 : m_rf[dbg_sel]);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    we0 = 0; we1 = 0; rsv_en = 0; clr_req = 0;
  endtask

  initial begin
    int bc, dc;
    rst = 1;
    quiet();
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra1 = 0; ra2 = 0; rsv_addr = 0; dbg_sel = 0;
    model_reset();
    @(posedge clk); #1;
    chk("reset_clr_busy", clr_busy, 0);
    chk("reset_clr_done", clr_done, 0);
    chk("reset_rd1", rd1, 0);
    cyc();
    rst = 0;
    cyc();

    // Forwarding then stored read
    we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF; ra1 = 3;
    #1 chk("bypass_rd1", rd1, 32'hDEADBEEF);
    cyc();
    we0 = 0;
    #1 chk("stored_rd1", rd1, 32'hDEADBEEF);
    cyc();

    // Same-address collision and r0 write
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22;
    cyc();
    quiet(); ra1 = 7;
    #1 chk("collision_port1_wins", rd1, 32'h22);
    we0 = 1; wa0 = 0; wd0 = 32'hFF; ra2 = 0;
    cyc();
    quiet();
    #1 chk("r0_reads_zero", rd2, 0);
    cyc();

    // Reservation and clear-by-write
    rsv_en = 1; rsv_addr = 5; ra2 = 5;
    cyc();
    quiet();
    #1 chk("rsv_busy2", busy2, 1);
    we1 = 1; wa1 = 5; wd1 = 32'h55;
    #1 chk("fwd_masks_busy2", busy2, 0);
    cyc();
    quiet();
    #1 chk("pend5_cleared", busy2, 0);
    cyc();

    // Reserve and write same register: reservation wins
    rsv_en = 1; rsv_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h99;
    cyc();
    quiet(); ra1 = 9;
    #1 chk("pend9_set", busy1, 1);
    chk("rf9_written", rd1, 32'h99);
    cyc();

    // Full clear with an ignored write mid-clear
    for (int i = 1; i < NREG; i++) begin
      we0 = 1; wa0 = AW'(i); wd0 = $urandom() | 32'h1;
      cyc();
    end
    quiet();
    rsv_en = 1; rsv_addr = 6;
    clr_req = 1;
    cyc();
    quiet();
    bc = 0; dc = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin
        we0 = 1; wa0 = 4; wd0 = 32'hABCD;
      end else begin
        we0 = 0;
      end
      #1;
      if (clr_busy) bc++;
      if (clr_done) dc++;
      cyc();
    end
    quiet();
    chk("clear_busy_cycles", bc, 32);
    chk("clear_done_pulses", dc, 1);
    for (int i = 0; i < NREG; i++) begin
      ra1 = AW'(i); ra2 = AW'(i); dbg_sel = AW'(i);
      #1 chk("cleared_reg", dbg_data, 0);
      chk("cleared_pend", busy1, 0);
      cyc();
    end

    // Reset in the middle of a clear
    for (int i = 1; i < 16; i++) begin
      we0 = 1; wa0 = AW'(i); wd0 = 32'h1000 + i;
      cyc();
    end
    quiet();
    clr_req = 1;
    cyc();
    quiet();
    repeat (10) cyc();
    rst = 1;
    model_reset();
    dbg_sel = 12;
    #1 chk("rst_abort_busy", clr_busy, 0);
    chk("rst_abort_done", clr_done, 0);
    chk("rst_abort_r12", dbg_data, 0);
    cyc();
    rst = 0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      dbg_sel = AW'(i);
      #1;
      if (clr_done) dc++;
      cyc();
    end
    chk("no_done_after_abort", dc, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      we0 = ($urandom_range(0, 1) == 1);
      we1 = ($urandom_range(0, 1) == 1);
      wa0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom());
      wa1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom());
      wd0 = $urandom();
      wd1 = $urandom();
      ra1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom());
      ra2 = AW'($urandom_range(0, 7));
      rsv_en = ($urandom_range(0, 9) < 3);
      rsv_addr = AW'($urandom_range(0, 7));
      clr_req = ($urandom_range(0, 99) < 2);
      dbg_sel = AW'($urandom());
      cyc();
    end
    quiet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
